fuzzy_sequencer: RTL and testbench
==================================

# fuzzy_sequencer

Central controller for the fuzzy duty-cycle pipeline (digitization → fuzzification → rule-base inference → defuzzification). It captures one 8-bit BCD sample per trigger, manual or periodic, and steps the four stages with one-hot enables, each held for its configured latency. It then latches the defuzzified duty into a stable output register and flags it valid. It sits in the top level between the ADC input and the four stage instances, replacing free-running operation with ordered, one-sample-at-a-time processing.

## Interface
- DIG_LAT, 1: cycles en_digitize is held (≥1)
- FUZ_LAT, 1: cycles en_fuzzify is held (≥1)
- INF_LAT, 1: cycles en_infer is held (≥1)
- DEF_LAT, 1: cycles en_defuzz is held (≥1)
- PERIOD, 100: auto-trigger interval in cycles (≥2)
- DUTY_RESET, 8'd0: duty_out value after reset
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  manual trigger, sampled each cycle
- auto_en  in  1  enables the periodic trigger
- bcd_in  in  8  raw ADC sample
- pwm_duty_in  in  8  duty from defuzzification stage
- bcd_hold  out  8  sample frozen for the pipeline
- en_digitize / en_fuzzify / en_infer / en_defuzz  out  1 each  stage enables, at most one high
- duty_out  out  8  last committed duty
- duty_valid  out  1  one-cycle pulse on commit
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  one-cycle pulse: trigger dropped

## Operation
- States: IDLE, DIG, FUZ, INF, DEF, UPDATE. Stage counter cnt is cleared on every state entry.
- trigger = start | tick. The tick comes from the period timer.
- IDLE with trigger: bcd_hold <= bcd_in, go to DIG.
- IDLE without trigger: remain in IDLE and hold all registers.
- Stage state X (DIG/FUZ/INF/DEF): its enable is high, decoded combinationally from state. When cnt == X_LAT-1, advance: DIG→FUZ→INF→DEF→UPDATE. Otherwise cnt++.
- UPDATE lasts one cycle. At its closing edge: duty_out <= pwm_duty_in, duty_valid <= 1, go to IDLE.
- Trigger while state ≠ IDLE (including UPDATE): the trigger is dropped, overrun pulses for one cycle, and bcd_hold is unchanged.
- start and tick in the same cycle count as one trigger. Only one capture occurs. No overrun is raised for the coincidence itself.
- Period timer:
  - counter resets to 0 while auto_en=0.
  - While auto_en=1 it counts 0..PERIOD-1 and wraps.
  - tick is asserted for one cycle when count == PERIOD-1.
  - The timer runs regardless of FSM state.
- bcd_hold and duty_out change only at capture and commit respectively. Pipeline glitches never reach duty_out.
- Reset (asynchronous, any state):
  - state=IDLE, cnt=0, timer=0
  - bcd_hold=0, duty_out=DUTY_RESET
  - duty_valid=0, overrun=0, all enables 0
  - An in-flight sample is discarded and no commit occurs.

## Timing
- Trigger sampled at edge E0: bcd_hold is valid after E0. en_digitize is high during cycles E0..E0+DIG_LAT.
- The enables are contiguous and non-overlapping, with no gap cycles between stages.
- duty_out updates at edge E0+L, with L = DIG_LAT+FUZ_LAT+INF_LAT+DEF_LAT+1. duty_valid is high for exactly the cycle following that edge.
- With default latencies L = 5.
- busy rises after E0 and falls after the commit edge.
- A new trigger is accepted in the same cycle duty_valid is high, giving back-to-back throughput of one sample per L+1 cycles.
- With auto_en=1, PERIOD must be ≥ L+1 to avoid overrun; this is not enforced.
- Registered outputs: duty_out, duty_valid, overrun, bcd_hold. Combinational from state: the enables and busy.
- cnt width is $clog2 of the largest stage latency, minimum 1 bit. Timer width is $clog2(PERIOD).

## Structure
- fuzzy_pkg holds the state enum (fsm_state_t) and the default stage latencies as localparams. Shared with the stage modules.
- One sub-module: sample_timer (PERIOD param; clk, rst, auto_en → tick).
- FSM, counter and output registers live in fuzzy_sequencer. No other hierarchy.

## Test plan
- Reset mid-DEF with duty_out=8'h40 → immediately duty_out=DUTY_RESET(0), busy=0, all enables 0, and no duty_valid afterwards.
- Default latencies, start pulse with bcd_in=8'h37, pwm_duty_in model = 8'h5A → bcd_hold=8'h37 after E0. en_digitize/en_fuzzify/en_infer/en_defuzz each high for one cycle in order. duty_out=8'h5A at E0+5. duty_valid pulses once.
- DIG_LAT=3, INF_LAT=2 → enables held 3/1/2/1 cycles, duty_valid at E0+8, and at no point more than one enable high.
- start re-asserted at E0+2 → overrun pulses once, bcd_hold unchanged, exactly one duty_valid.
- auto_en=1, PERIOD=10, no start → tick every 10 cycles, commits at 10k+5. Then start and tick in the same cycle → single capture, no overrun.
- auto_en=1, PERIOD=4 (< L+1) → every other tick produces an overrun pulse and commits occur every 8 cycles.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared types and defaults for the fuzzy duty-cycle pipeline controller and its stages.
package fuzzy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIG,
        ST_FUZ,
        ST_INF,
        ST_DEF,
        ST_UPDATE
    } fsm_state_t;

    localparam int DIG_LAT_DEFAULT = 1;
    localparam int FUZ_LAT_DEFAULT = 1;
    localparam int INF_LAT_DEFAULT = 1;
    localparam int DEF_LAT_DEFAULT = 1;

    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A counter for a latency of 1 still needs one bit to exist.
    function automatic int cnt_width(input int max_latency);
        return (max_latency <= 1) ? 1 : $clog2(max_latency);
    endfunction

    function automatic fsm_state_t next_stage(input fsm_state_t s);
        case (s)
            ST_DIG:  return ST_FUZ;
            ST_FUZ:  return ST_INF;
            ST_INF:  return ST_DEF;
            default: return ST_UPDATE;
        endcase
    endfunction

endpackage

// File: rtl/fuzzy_sequencer_sample_timer.sv
// Periodic trigger source: one-cycle tick every PERIOD cycles while auto_en is high.
module sample_timer
    import fuzzy_pkg::*;
#(
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic auto_en,
    output logic tick
);

    localparam int TW = $clog2(PERIOD);
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!auto_en) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = auto_en && (r_count == LAST);

endmodule

// File: rtl/fuzzy_sequencer.sv
// Steps one captured BCD sample through the four pipeline stages and commits the resulting duty.
module fuzzy_sequencer
    import fuzzy_pkg::*;
#(
    parameter int         DIG_LAT    = DIG_LAT_DEFAULT,
    parameter int         FUZ_LAT    = FUZ_LAT_DEFAULT,
    parameter int         INF_LAT    = INF_LAT_DEFAULT,
    parameter int         DEF_LAT    = DEF_LAT_DEFAULT,
    parameter int         PERIOD     = 100,
    parameter logic [7:0] DUTY_RESET = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       auto_en,
    input  logic [7:0] bcd_in,
    input  logic [7:0] pwm_duty_in,
    output logic [7:0] bcd_hold,
    output logic       en_digitize,
    output logic       en_fuzzify,
    output logic       en_infer,
    output logic       en_defuzz,
    output logic [7:0] duty_out,
    output logic       duty_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int CW = cnt_width(max_lat(DIG_LAT, FUZ_LAT, INF_LAT, DEF_LAT));

    fsm_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_bcd_hold;
    logic [7:0]    r_duty_out;
    logic          r_duty_valid;
    logic          r_overrun;
    logic          w_tick;
    logic          w_trigger;
    logic [CW-1:0] w_stage_last;

    sample_timer #(.PERIOD(PERIOD)) u_sample_timer (
        .clk     (clk),
        .rst     (rst),
        .auto_en (auto_en),
        .tick    (w_tick)
    );

    // Coincident start and tick collapse into one trigger.
    assign w_trigger = start | w_tick;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_stage_last = '0;
        case (r_state)
            ST_DIG:  w_stage_last = CW'(DIG_LAT - 1);
            ST_FUZ:  w_stage_last = CW'(FUZ_LAT - 1);
            ST_INF:  w_stage_last = CW'(INF_LAT - 1);
            ST_DEF:  w_stage_last = CW'(DEF_LAT - 1);
            default: w_stage_last = '0;
        endcase
    end

    // NOTE: there are no memories here; every register has a reset value, so reset discards in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bcd_hold   <= 8'd0;
            r_duty_out   <= DUTY_RESET;
            r_duty_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            r_overrun    <= w_trigger && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_bcd_hold <= bcd_in;
                        r_state    <= ST_DIG;
                        r_cnt      <= '0;
                    end
                end
                ST_DIG, ST_FUZ, ST_INF, ST_DEF: begin
                    if (r_cnt == w_stage_last) begin
                        r_cnt   <= '0;
                        r_state <= next_stage(r_state);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_duty_out   <= pwm_duty_in;
                    r_duty_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                    r_cnt        <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign en_digitize = (r_state == ST_DIG);
    assign en_fuzzify  = (r_state == ST_FUZ);
    assign en_infer    = (r_state == ST_INF);
    assign en_defuzz   = (r_state == ST_DEF);
    assign busy        = (r_state != ST_IDLE);
    assign bcd_hold    = r_bcd_hold;
    assign duty_out    = r_duty_out;
    assign duty_valid  = r_duty_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_fuzzy_sequencer.sv
// Randomized scoreboard bench: three sequencer configurations checked against a cycle-indexed reference model.
module tb_fuzzy_sequencer;

    localparam int NI   = 3;
    localparam int NCYC = 2048;

    // Instance 0: default latencies, PERIOD=10; 1: default, PERIOD=4; 2: latencies 3/1/2/1, PERIOD=100.
    function automatic int lat_of(input int i, input int s);
        if (i == 2) begin
            case (s)
                0: return 3;
                2: return 2;
                default: return 1;
            endcase
        end
        return 1;
    endfunction

    function automatic int period_of(input int i);
        case (i)
            0: return 10;
            1: return 4;
            default: return 100;
        endcase
    endfunction

    // Edge distance from capture to commit.
    function automatic int total_of(input int i);
        return lat_of(i, 0) + lat_of(i, 1) + lat_of(i, 2) + lat_of(i, 3) + 1;
    endfunction

    // One-hot enable expected d cycles after the capture edge (bit0 = digitize).
    function automatic logic [3:0] stage_en(input int i, input int d);
        int acc_lat;
        acc_lat = 0;
        for (int s = 0; s < 4; s++) begin
            acc_lat += lat_of(i, s);
            if (d <= acc_lat) return 4'(1 << s);
        end
        return 4'b0000;
    endfunction

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] duty;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] bcd_in = 8'd0;
    logic [7:0] pwm_duty_in = 8'd0;
    logic [NI-1:0] st = '0;
    logic [NI-1:0] ae = '0;

    wire [NI-1:0][7:0] bh;
    wire [NI-1:0][7:0] dout;
    wire [NI-1:0][3:0] en;
    wire [NI-1:0]      dv;
    wire [NI-1:0]      bz;
    wire [NI-1:0]      ov;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] pwm_seq [NCYC];
    int         acc [NI];
    int         tcnt [NI];
    logic [7:0] m_bcd [NI];
    logic [7:0] m_duty [NI];
    ev_t        q_commit [$];
    ev_t        q_ovr [$];

    fuzzy_sequencer #(.PERIOD(10)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .auto_en(ae[0]), .bcd_in(bcd_in),
        .pwm_duty_in(pwm_duty_in), .bcd_hold(bh[0]), .en_digitize(en[0][0]),
        .en_fuzzify(en[0][1]), .en_infer(en[0][2]), .en_defuzz(en[0][3]),
        .duty_out(dout[0]), .duty_valid(dv[0]), .busy(bz[0]), .overrun(ov[0])
    );

    fuzzy_sequencer #(.PERIOD(4)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .auto_en(ae[1]), .bcd_in(bcd_in),
        .pwm_duty_in(pwm_duty_in), .bcd_hold(bh[1]), .en_digitize(en[1][0]),
        .en_fuzzify(en[1][1]), .en_infer(en[1][2]), .en_defuzz(en[1][3]),
        .duty_out(dout[1]), .duty_valid(dv[1]), .busy(bz[1]), .overrun(ov[1])
    );

    fuzzy_sequencer #(.DIG_LAT(3), .INF_LAT(2), .PERIOD(100)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .auto_en(ae[2]), .bcd_in(bcd_in),
        .pwm_duty_in(pwm_duty_in), .bcd_hold(bh[2]), .en_digitize(en[2][0]),
        .en_fuzzify(en[2][1]), .en_infer(en[2][2]), .en_defuzz(en[2][3]),
        .duty_out(dout[2]), .duty_valid(dv[2]), .busy(bz[2]), .overrun(ov[2])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle and drive this cycle's default inputs.
    task automatic step();
        @(posedge clk);
        #1;
        pwm_duty_in = pwm_seq[cyc % NCYC];
        bcd_in      = 8'($urandom);
        st          = '0;
    endtask

    // Reference model: evaluates the cycle whose inputs are now stable, then advances.
    always @(negedge clk) begin
        int L;
        int d;
        int p;
        logic trig;
        logic [3:0] exp_en;
        logic exp_busy;
        for (int i = 0; i < NI; i++) begin
            L = total_of(i);
            p = period_of(i);
            if (rst) begin
                acc[i]    = -1;
                tcnt[i]   = 0;
                m_bcd[i]  = 8'd0;
                m_duty[i] = 8'd0;
                for (int k = q_commit.size() - 1; k >= 0; k--)
                    if (q_commit[k].inst == i) q_commit.delete(k);
                for (int k = q_ovr.size() - 1; k >= 0; k--)
                    if (q_ovr[k].inst == i) q_ovr.delete(k);
                check($sformatf("reset_outputs[%0d]", i),
                      {8'(en[i]), 8'(bh[i]), 8'(dout[i]), 5'd0, bz[i], dv[i], ov[i]}, 32'd0);
            end else begin
                if (acc[i] >= 0 && cyc == acc[i] + L + 1)
                    m_duty[i] = pwm_seq[(acc[i] + L) % NCYC];
                d        = cyc - acc[i];
                exp_en   = 4'b0000;
                exp_busy = (acc[i] >= 0) && (d >= 1) && (d <= L);
                if (acc[i] >= 0 && d >= 1 && d <= L - 1) exp_en = stage_en(i, d);
                check($sformatf("enables[%0d]", i), 32'(en[i]), 32'(exp_en));
                check($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(exp_busy));
                check($sformatf("bcd_hold[%0d]", i), 32'(bh[i]), 32'(m_bcd[i]));
                check($sformatf("duty_out[%0d]", i), 32'(dout[i]), 32'(m_duty[i]));

                trig = st[i] | (ae[i] && (tcnt[i] == p - 1));
                if (trig) begin
                    if (acc[i] < 0 || cyc >= acc[i] + L + 1) begin
                        acc[i]   = cyc;
                        m_bcd[i] = bcd_in;
                        q_commit.push_back('{inst: i, cyc: cyc + L + 1,
                                             duty: pwm_seq[(cyc + L) % NCYC]});
                    end else begin
                        q_ovr.push_back('{inst: i, cyc: cyc + 1, duty: 8'd0});
                    end
                end
                tcnt[i] = ae[i] ? (tcnt[i] + 1) % p : 0;
            end
        end
    end

    // Monitor: matches every commit and overrun pulse against the scoreboard queues.
    always @(negedge clk) begin
        int k;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (dv[i]) begin
                    k = -1;
                    for (int j = 0; j < q_commit.size() && k < 0; j++)
                        if (q_commit[j].inst == i) k = j;
                    if (k < 0) begin
                        check($sformatf("unexpected_commit[%0d]", i), 32'(dv[i]), 32'd0);
                    end else begin
                        check($sformatf("commit_cycle[%0d]", i), cyc, q_commit[k].cyc);
                        check($sformatf("commit_duty[%0d]", i), 32'(dout[i]), 32'(q_commit[k].duty));
                        q_commit.delete(k);
                    end
                end
                if (ov[i]) begin
                    k = -1;
                    for (int j = 0; j < q_ovr.size() && k < 0; j++)
                        if (q_ovr[j].inst == i) k = j;
                    if (k < 0) begin
                        check($sformatf("unexpected_overrun[%0d]", i), 32'(ov[i]), 32'd0);
                    end else begin
                        check($sformatf("overrun_cycle[%0d]", i), cyc, q_ovr[k].cyc);
                        q_ovr.delete(k);
                    end
                end
            end
        end
        for (int j = q_commit.size() - 1; j >= 0; j--) begin
            if (q_commit[j].cyc < cyc) begin
                check($sformatf("missing_commit[%0d]", q_commit[j].inst), cyc, q_commit[j].cyc);
                q_commit.delete(j);
            end
        end
        for (int j = q_ovr.size() - 1; j >= 0; j--) begin
            if (q_ovr[j].cyc < cyc) begin
                check($sformatf("missing_overrun[%0d]", q_ovr[j].inst), cyc, q_ovr[j].cyc);
                q_ovr.delete(j);
            end
        end
    end

    initial begin
        for (int j = 0; j < NCYC; j++) pwm_seq[j] = 8'($urandom);
        for (int i = 0; i < NI; i++) begin
            acc[i]    = -1;
            tcnt[i]   = 0;
            m_bcd[i]  = 8'd0;
            m_duty[i] = 8'd0;
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Single sample with default latencies.
        step();
        bcd_in = 8'h37;
        st[0]  = 1'b1;
        pwm_seq[(cyc + 5) % NCYC] = 8'h5A;
        step();
        check("bcd_hold_after_capture", 32'(bh[0]), 32'h37);
        repeat (8) step();
        check("duty_out_committed", 32'(dout[0]), 32'h5A);

        // Re-trigger two cycles into a sample: one overrun, one commit.
        step();
        st[0] = 1'b1;
        step();
        step();
        st[0] = 1'b1;
        repeat (8) step();

        // Long-latency configuration commits 8'h40.
        step();
        st[2] = 1'b1;
        pwm_seq[(cyc + 8) % NCYC] = 8'h40;
        repeat (12) step();
        check("duty_out_long_latency", 32'(dout[2]), 32'h40);

        // Periodic triggering, then start coinciding with a tick.
        ae[0] = 1'b1;
        repeat (60) step();
        for (int c = 0; c < 20; c++) begin
            step();
            if (tcnt[0] == period_of(0) - 1) begin
                st[0] = 1'b1;
                break;
            end
        end
        repeat (15) step();
        ae[0] = 1'b0;

        // Period shorter than the sample latency.
        ae[1] = 1'b1;
        repeat (40) step();
        ae[1] = 1'b0;
        repeat (10) step();

        // Randomized traffic on all instances.
        for (int c = 0; c < 300; c++) begin
            step();
            if (c % 50 == 0) ae = NI'($urandom);
            for (int i = 0; i < NI; i++) st[i] = ($urandom_range(0, 4) == 0);
        end
        ae = '0;
        repeat (20) step();

        // Asynchronous reset in the middle of DEF.
        step();
        st[2] = 1'b1;
        pwm_seq[(cyc + 8) % NCYC] = 8'h40;
        repeat (10) step();
        check("duty_before_reset", 32'(dout[2]), 32'h40);
        step();
        st[2] = 1'b1;
        repeat (7) step();
        check("in_defuzz_before_reset", 32'(en[2]), 32'b1000);
        rst = 1'b1;
        #1;
        check("reset_duty_out", 32'(dout[2]), 32'h00);
        check("reset_busy", 32'(bz[2]), 32'd0);
        check("reset_enables", 32'(en[2]), 32'd0);
        step();
        rst = 1'b0;
        repeat (12) step();

        check("commit_queue_drained", q_commit.size(), 0);
        check("overrun_queue_drained", q_ovr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
